// File: rtl/div_fix_point.sv
// div_fix_point: signed Q-format divider, bit-serial restoring, start/busy/done.
// Define DIV_FIX_POINT_ROUND_EN for round-half-away-from-zero (one extra cycle).
module div_fix_point #(
  parameter int Q = 14,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);

`ifdef DIV_FIX_POINT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int IT = N + Q + RND;
  localparam int CW = $clog2(IT);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nx;

  logic          sign;
  logic          dz;
  logic [N-1:0]  b_mag;
  logic [N:0]    rem;
  logic [IT-1:0] qr;
  logic [CW-1:0] cnt;

  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic [N+1:0]  rem_sh;
  logic [N:0]    b_ext;
  logic [N:0]    sub;
  logic          q_bit;
  logic [IT-1:0] mag;
  logic [N-1:0]  lim;
  logic          ovf;
  logic [N-1:0]  sat;
  logic [N-1:0]  q_fin;

  assign busy = (state != IDLE);

  assign a_in = dividend[N-1] ? -dividend : dividend;
  assign b_in = divisor[N-1]  ? -divisor  : divisor;

  // numerator bits leave qr from the top while quotient bits enter at the bottom
  assign rem_sh = {rem, qr[IT-1]};
  assign b_ext  = {1'b0, b_mag};
  assign q_bit  = (rem_sh >= {1'b0, b_ext});
  assign sub    = rem_sh[N:0] - b_ext;

`ifdef DIV_FIX_POINT_ROUND_EN
  assign mag = {1'b0, qr[IT-1:1]} + IT'(qr[0]);
`else
  assign mag = qr;
`endif

  assign lim   = sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign ovf   = (mag > {{(IT-N){1'b0}}, lim});
  assign sat   = ovf ? lim : mag[N-1:0];
  assign q_fin = dz ? lim : (sign ? -sat : sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (b_in == '0) ? FIN : CALC;
      end
      CALC: begin
        if (cnt == CW'(IT-1)) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign        <= 1'b0;
      dz          <= 1'b0;
      b_mag       <= '0;
      rem         <= '0;
      qr          <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign        <= dividend[N-1] ^ divisor[N-1];
            dz          <= (b_in == '0);
            b_mag       <= b_in;
            rem         <= '0;
            qr          <= {a_in, {(IT-N){1'b0}}};
            cnt         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          qr  <= {qr[IT-2:0], q_bit};
          rem <= q_bit ? sub : rem_sh[N:0];
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          done        <= 1'b1;
          quotient    <= q_fin;
          overflow    <= ovf & ~dz;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fix_point.sv
// tb_div_fix_point: directed vectors for div_fix_point.
// Expected values follow DIV_FIX_POINT_ROUND_EN when it is defined.
module tb_div_fix_point;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

`ifdef DIV_FIX_POINT_ROUND_EN
  localparam int          LAT = 32;
  localparam logic [15:0] QP  = 16'h2AAB;
  localparam logic [15:0] QN  = 16'hD555;
`else
  localparam int          LAT = 31;
  localparam logic [15:0] QP  = 16'h2AAA;
  localparam logic [15:0] QN  = 16'hD556;
`endif

  div_fix_point dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string       tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input bit          now,
                        input int          poke,
                        input logic [15:0] eq,
                        input logic        eov,
                        input logic        edz,
                        input int          elat);
    int n;
    bit seen;
    if (!now) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (done) seen = 1'b1;
      else if (n == poke) begin
        start    = 1'b1;
        dividend = 16'h6000;
        divisor  = 16'h2000;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_ov"}, 32'(overflow), 32'(eov));
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("pos",  16'h2000, 16'h3000, 0, 0, QP, 0, 0, LAT);
    run_op("neg",  16'h2000, 16'hD000, 0, 0, QN, 0, 0, LAT);
    run_op("m1",   16'hC000, 16'h4000, 0, 0, 16'hC000, 0, 0, LAT);
    run_op("sat3", 16'h6000, 16'h2000, 0, 0, 16'h7FFF, 1, 0, LAT);
    run_op("m2",   16'h8000, 16'h4000, 0, 0, 16'h8000, 0, 0, LAT);
    run_op("p2",   16'h8000, 16'hC000, 0, 0, 16'h7FFF, 1, 0, LAT);
    run_op("dzp",  16'h1234, 16'h0000, 0, 0, 16'h7FFF, 0, 1, 1);
    run_op("dzn",  16'hF000, 16'h0000, 0, 0, 16'h8000, 0, 1, 1);
    run_op("poke", 16'h2000, 16'h3000, 0, 5, QP, 0, 0, LAT);

    run_op("b2b1", 16'h2000, 16'hD000, 0, 0, QN, 0, 0, LAT);
    chk("b2b_done", 32'(done), 32'd1);
    run_op("b2b2", 16'h4000, 16'h4000, 1, 0, 16'h4000, 0, 0, LAT);

    @(negedge clk);
    dividend = 16'h2000;
    divisor  = 16'h3000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_q0", 32'(quotient), 32'd0);
    chk("abort_done0", 32'(done), 32'd0);
    chk("abort_ov0", 32'(overflow), 32'd0);
    chk("abort_dz0", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_op("after", 16'h4000, 16'h4000, 0, 0, 16'h4000, 0, 0, LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
